// File: rtl/ssc_pkg.sv
// Shared definitions for the register-bank write-back arbiter.
// Contents: bank geometry constants, the controller state enum and a
// helper that sizes requester-index fields.
// No ports (package).
package ssc_pkg;

  localparam int SSC_DATA_W   = 32;
  localparam int SSC_REG_AW   = 3;
  localparam int SSC_NUM_REGS = 8;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } ssc_state_t;

  // Width of an index into n requesters; never below one bit.
  function automatic int ssc_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ssc_regbank_wb_arbiter_if.sv
// Bus bundle between the write-back requesters and the register-bank
// write-port controller.
// Signals:
//   Stall                          freeze request from the pipeline
//   Req_Valid / Req_Dest / Req_Data per-requester packed write requests
//   Req_Ready                      one-hot combinational grant
//   RB_ClkEnable / RB_wEnable /
//   RB_DestReg / RB_WBData         registered bank write-port drive
//   Init_Done                      clear sweep finished
//   Grant_Idx                      index of last accepted requester
// Modports: master = requester/pipeline side, slave = controller side.
interface ssc_regbank_wb_arbiter_if
  import ssc_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = SSC_DATA_W,
  parameter int REG_AW  = SSC_REG_AW
);
  localparam int IDX_W = ssc_idx_w(NUM_REQ);

  logic                        Stall;
  logic [NUM_REQ-1:0]          Req_Valid;
  logic [NUM_REQ*REG_AW-1:0]   Req_Dest;
  logic [NUM_REQ*DATA_W-1:0]   Req_Data;
  logic [NUM_REQ-1:0]          Req_Ready;
  logic                        RB_ClkEnable;
  logic                        RB_wEnable;
  logic [REG_AW-1:0]           RB_DestReg;
  logic [DATA_W-1:0]           RB_WBData;
  logic                        Init_Done;
  logic [IDX_W-1:0]            Grant_Idx;

  modport master (
    output Stall, Req_Valid, Req_Dest, Req_Data,
    input  Req_Ready, RB_ClkEnable, RB_wEnable, RB_DestReg, RB_WBData,
           Init_Done, Grant_Idx
  );

  modport slave (
    input  Stall, Req_Valid, Req_Dest, Req_Data,
    output Req_Ready, RB_ClkEnable, RB_wEnable, RB_DestReg, RB_WBData,
           Init_Done, Grant_Idx
  );

endinterface

// File: rtl/ssc_wb_arb_core.sv
// Combinational one-hot grant logic for the write-back arbiter.
// The search starts at requester 'ptr' and wraps modulo NUM_REQ; the
// first asserted request wins. Tying ptr to zero gives fixed priority
// (lowest index wins).
// Ports:
//   valid     in   per-requester request bits
//   ptr       in   first index searched
//   grant     out  one-hot winner (zero when nothing is valid)
//   grant_idx out  binary index of the winner
//   any       out  some request is valid
module ssc_wb_arb_core
  import ssc_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = ssc_idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any
);

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!any && valid[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = IDX_W'(idx);
        any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ssc_regbank_wb_arbiter.sv
// Write-port controller for the 8 x 32-bit single-write-port register bank.
// After reset it writes zero to every register (one per unstalled cycle),
// then shares the write port among NUM_REQ valid/ready requesters. The
// bank-side outputs are registered: a handshake in cycle n becomes the
// write strobe in cycle n+1.
// Ports:
//   Clk      in  rising-edge clock
//   Reset_n  in  asynchronous active-low reset
//   bus      slave side of ssc_regbank_wb_arbiter_if (requests, grant,
//            bank drive, Init_Done, Grant_Idx)
// Build option: define SSC_WB_RR_ARB_EN for round-robin arbitration;
// without it the arbitration is fixed priority and no pointer is kept.
module ssc_regbank_wb_arbiter
  import ssc_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = SSC_DATA_W,
  parameter int REG_AW  = SSC_REG_AW
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  ssc_regbank_wb_arbiter_if.slave bus
);

  localparam int IDX_W = ssc_idx_w(NUM_REQ);

  ssc_state_t          state, state_nxt;
  logic [REG_AW-1:0]   cnt, cnt_nxt;
  logic                cke_p1;
  logic                vld_p1, vld_nxt;
  logic [REG_AW-1:0]   dest_p1, dest_nxt;
  logic [DATA_W-1:0]   data_p1, data_nxt;
  logic [IDX_W-1:0]    gidx_p1, gidx_nxt;
  logic                done_p1, done_nxt;

  logic [NUM_REQ-1:0]  grant;
  logic [IDX_W-1:0]    win_idx;
  logic                any_req;
  logic                run_ok;
  logic                xfer;
  logic [IDX_W-1:0]    rr_ptr;

`ifdef SSC_WB_RR_ARB_EN
  logic [IDX_W-1:0]    rr_ptr_nxt;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) rr_ptr <= '0;
    else          rr_ptr <= rr_ptr_nxt;
  end

  // Pointer moves just past the winner on every transfer.
  always_comb begin
    rr_ptr_nxt = rr_ptr;
    if (xfer)
      rr_ptr_nxt = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
  end
`else
  assign rr_ptr = '0;
`endif

  ssc_wb_arb_core #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_core (
    .valid     (bus.Req_Valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (win_idx),
    .any       (any_req)
  );

  // Stage p0: combinational grant; only offered while running and unstalled.
  assign run_ok        = (state == ST_RUN) && !bus.Stall;
  assign xfer          = run_ok && any_req;
  assign bus.Req_Ready = run_ok ? grant : '0;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    vld_nxt   = 1'b0;
    dest_nxt  = dest_p1;
    data_nxt  = data_p1;
    gidx_nxt  = gidx_p1;
    done_nxt  = done_p1;
    case (state)
      ST_INIT: begin
        if (!bus.Stall) begin
          vld_nxt  = 1'b1;
          dest_nxt = cnt;
          data_nxt = '0;
          cnt_nxt  = cnt + 1'b1;
          // Leave INIT on the same edge as the last clear write.
          if (cnt == '1) begin
            state_nxt = ST_RUN;
            done_nxt  = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (xfer) begin
          vld_nxt  = 1'b1;
          dest_nxt = bus.Req_Dest[win_idx*REG_AW +: REG_AW];
          data_nxt = bus.Req_Data[win_idx*DATA_W +: DATA_W];
          gidx_nxt = win_idx;
        end
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  // Stage p1: registered bank write-port drive.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= ST_INIT;
      cnt     <= '0;
      cke_p1  <= 1'b0;
      vld_p1  <= 1'b0;
      dest_p1 <= '0;
      data_p1 <= '0;
      gidx_p1 <= '0;
      done_p1 <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      cke_p1  <= !bus.Stall;
      vld_p1  <= vld_nxt;
      dest_p1 <= dest_nxt;
      data_p1 <= data_nxt;
      gidx_p1 <= gidx_nxt;
      done_p1 <= done_nxt;
    end
  end

  assign bus.RB_ClkEnable = cke_p1;
  assign bus.RB_wEnable   = vld_p1;
  assign bus.RB_DestReg   = dest_p1;
  assign bus.RB_WBData    = data_p1;
  assign bus.Grant_Idx    = gidx_p1;
  assign bus.Init_Done    = done_p1;

endmodule
